// File: rtl/axi_burst_beat_gen.sv
// AXI4 burst beat generator: takes one AW/AR command and emits one registered
// beat descriptor (address, lanes, strobe, index, last, error) per beat.
module axi_burst_beat_gen #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4,
    localparam int StrbWidth = DataWidth / 8,
    localparam int LaneWidth = (StrbWidth > 1) ? $clog2(StrbWidth) : 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    input  logic [IdWidth-1:0]   ax_id_i,
    output logic                 beat_valid_o,
    input  logic                 beat_ready_i,
    output logic [AddrWidth-1:0] beat_addr_o,
    output logic [7:0]           beat_idx_o,
    output logic                 beat_last_o,
    output logic [LaneWidth-1:0] beat_lower_o,
    output logic [LaneWidth-1:0] beat_upper_o,
    output logic [StrbWidth-1:0] beat_strb_o,
    output logic [IdWidth-1:0]   beat_id_o,
    output logic                 beat_err_o,
    output logic                 busy_o
);
    // state   | meaning
    // S_IDLE  | waiting for a command, ax_ready_o high
    // S_BURST | presenting beat descriptors until the last one is taken

    localparam int MaxSize = $clog2(StrbWidth);
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;
    localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t state_q, state_d;

    logic [AddrWidth-1:0] cmd_addr_q;
    logic [7:0]           cmd_len_q;
    logic [2:0]           cmd_size_q;
    logic [1:0]           cmd_burst_q;

    logic load, advance;

    function automatic logic [LaneWidth-1:0] lane_of(input logic [AddrWidth-1:0] a);
        return LaneWidth'(a & AddrWidth'(StrbWidth - 1));
    endfunction

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ax_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ax_ready_o = 1'b1;
                if (ax_valid_i) state_d = S_BURST;
            end
            S_BURST: begin
                ax_ready_o = beat_last_o && beat_ready_i;
                if (beat_last_o && beat_ready_i && !ax_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign beat_valid_o = (state_q == S_BURST);
    assign busy_o       = (state_q == S_BURST);
    assign load         = ax_valid_i && ax_ready_o;
    assign advance      = beat_valid_o && beat_ready_i && !beat_last_o;

    // Next descriptor: beat 0 of the incoming command, or beat idx+1 of the held one.
    logic [AddrWidth-1:0] src_addr, nbytes, aligned, total, boundary, step, last_addr, nxt_addr;
    logic [7:0]           src_len, nxt_idx;
    logic [2:0]           src_size;
    logic [1:0]           src_burst;
    logic                 start_lanes, nxt_err;
    logic [LaneWidth-1:0] nxt_lower, nxt_upper;
    logic [StrbWidth-1:0] nxt_strb;

    always_comb begin
        src_addr  = load ? ax_addr_i  : cmd_addr_q;
        src_len   = load ? ax_len_i   : cmd_len_q;
        src_size  = load ? ax_size_i  : cmd_size_q;
        src_burst = load ? ax_burst_i : cmd_burst_q;
        nxt_idx   = load ? 8'd0 : beat_idx_o + 8'd1;

        nbytes    = One << src_size;
        aligned   = (src_addr >> src_size) << src_size;
        total     = AddrWidth'({1'b0, src_len} + 9'd1) << src_size;
        boundary  = src_addr - (src_addr % total);
        step      = AddrWidth'(nxt_idx) << src_size;
        last_addr = aligned + (AddrWidth'(src_len) << src_size);

        nxt_addr = src_addr;
        if (src_burst == BurstWrap) begin
            nxt_addr = aligned + step;
            if (nxt_addr >= boundary + total) nxt_addr = nxt_addr - total;
        end else if (src_burst == BurstIncr && nxt_idx != 8'd0) begin
            nxt_addr = aligned + step;
        end

        start_lanes = (src_burst == BurstFixed) || (src_burst == BurstRsvd) || (nxt_idx == 8'd0);
        if (start_lanes) begin
            nxt_lower = lane_of(src_addr);
            nxt_upper = lane_of(aligned + nbytes - One);
        end else begin
            nxt_lower = lane_of(nxt_addr);
            nxt_upper = lane_of(AddrWidth'(nxt_lower) + nbytes - One);
        end

        nxt_strb = '0;
        for (int j = 0; j < StrbWidth; j++)
            nxt_strb[j] = (j >= int'(nxt_lower)) && (j <= int'(nxt_upper));

        nxt_err = (src_burst == BurstRsvd)
               || (int'(src_size) > MaxSize)
               || (src_burst == BurstWrap && !(src_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
               || (src_burst == BurstWrap && (src_addr & (nbytes - One)) != '0)
               || (src_burst == BurstFixed && src_len > 8'd15)
               || (src_burst == BurstIncr && last_addr[AddrWidth-1:12] != src_addr[AddrWidth-1:12]);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cmd_size_q   <= '0;
            cmd_burst_q  <= '0;
            beat_addr_o  <= '0;
            beat_idx_o   <= '0;
            beat_last_o  <= 1'b0;
            beat_lower_o <= '0;
            beat_upper_o <= '0;
            beat_strb_o  <= '0;
            beat_id_o    <= '0;
            beat_err_o   <= 1'b0;
        end else if (load || advance) begin
            if (load) begin
                cmd_addr_q  <= ax_addr_i;
                cmd_len_q   <= ax_len_i;
                cmd_size_q  <= ax_size_i;
                cmd_burst_q <= ax_burst_i;
                beat_id_o   <= ax_id_i;
                beat_err_o  <= nxt_err;
            end
            beat_addr_o  <= nxt_addr;
            beat_idx_o   <= nxt_idx;
            beat_last_o  <= (nxt_idx == src_len);
            beat_lower_o <= nxt_lower;
            beat_upper_o <= nxt_upper;
            beat_strb_o  <= nxt_strb;
        end
    end
endmodule

// File: doc/axi_burst_beat_gen.md
Name: axi_burst_beat_gen

Overview:
Sequential AXI4 burst address generator. Accepts one AW/AR command per valid/ready handshake, then emits one beat descriptor per beat: address, byte-lane window, strobe mask, index, last flag and error. This is the parametrised hardware counterpart of the package's beat-address helpers. It adds:
- all wrap lengths and sizes,
- protocol-error checks,
- back-to-back command acceptance.

It sits between the AXI slave front-end and the downstream data path (UART register/FIFO bridge).

Parameters:
AddrWidth, 32, address width in bits (>= 12)
DataWidth, 32, data-bus width in bits (power of two, 8..1024); StrbWidth = DataWidth/8
IdWidth, 4, transaction ID width, carried through unchanged

Ports:
clk_i  in  1  clock, all logic rising-edge
arst_i  in  1  asynchronous active-high reset
ax_valid_i  in  1  command valid
ax_ready_o  out  1  command ready
ax_addr_i  in  AddrWidth  start address
ax_len_i  in  8  beats minus one
ax_size_i  in  3  log2 bytes per beat
ax_burst_i  in  2  FIXED=00, INCR=01, WRAP=10, 11 reserved
ax_id_i  in  IdWidth  transaction ID
beat_valid_o  out  1  beat descriptor valid
beat_ready_i  in  1  beat consumed
beat_addr_o  out  AddrWidth  beat address
beat_idx_o  out  8  beat index, 0..len
beat_last_o  out  1  final beat of burst
beat_lower_o  out  $clog2(StrbWidth) (min 1)  lowest active byte lane
beat_upper_o  out  $clog2(StrbWidth) (min 1)  highest active byte lane
beat_strb_o  out  StrbWidth  lanes lower..upper set, others clear
beat_id_o  out  IdWidth  ID of current burst
beat_err_o  out  1  burst flagged illegal (constant for whole burst)
busy_o  out  1  burst in progress

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high on arst_i.
- Reset values: all outputs 0 except ax_ready_o, which is 1. Reset asserted mid-burst aborts immediately: state returns to IDLE and the remaining beats are dropped.
- States: IDLE, BURST.
  - IDLE: ax_ready_o=1, beat_valid_o=0. On ax handshake, register the command and go to BURST.
  - BURST: beat_valid_o=1, busy_o=1. The beat advances only when beat_valid_o && beat_ready_i.
- ax_ready_o in BURST = beat_last_o && beat_ready_i. A command accepted in the same cycle as the last-beat handshake produces its beat 0 on the next cycle, so there is no bubble. If no command is accepted on the last-beat handshake, go to IDLE.
- Latency: beat 0 is valid exactly one cycle after the ax handshake.
- Output stability: all beat_* outputs are registered and held stable while beat_valid_o=1 && beat_ready_i=0.
- Beat count: beat_last_o=1 when beat_idx_o==len. A burst emits len+1 beats; len=0 gives a single beat with last=1.
- Arithmetic: nbytes = 1<<size; aligned = (addr>>size)<<size.
  - FIXED: every beat address = addr.
  - INCR: beat i (i>0) = aligned + i*nbytes, modulo 2^AddrWidth.
  - WRAP: boundary = addr aligned down to nbytes*(len+1). Beat i = aligned + i*nbytes; if the result >= boundary + nbytes*(len+1), subtract nbytes*(len+1).
  - Reserved burst (11): addresses generated as FIXED, and err is set.
- Lanes:
  - beat 0: lower = addr mod StrbWidth; upper = (aligned + nbytes - 1) mod StrbWidth.
  - beat i>0: lower = beat_addr mod StrbWidth; upper = lower + nbytes - 1.
  - FIXED: every beat uses the beat-0 lanes.
- Errors: err=1 for the whole burst if any of the following hold:
  - ax_burst_i=11;
  - size > log2(StrbWidth);
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not size-aligned;
  - FIXED with len > 15;
  - INCR where the last beat's address lies in a different 4 KB page than addr.
- Error handling: an erroneous burst still emits all len+1 beats. The generator never stalls or drops beats on error.
- Bench ports: beat_idx_o and the internal beat counter are 8-bit. len=255 INCR completes with beat_idx_o=255 and last=1.

Test Plan (DataWidth=32, AddrWidth=32):
1. INCR addr=0x1002 size=2 len=3 -> addrs 0x1002/0x1004/0x1008/0x100C; strb 1100,1111,1111,1111; last on idx 3; err=0.
2. WRAP addr=0x1038 size=2 len=3 -> addrs 0x1038/0x103C/0x1030/0x1034; all strb 1111; err=0. Repeat with len=2 -> err=1 on all 3 beats.
3. FIXED addr=0x21 size=0 len=2 -> 3 beats at 0x21, strb 0010, lower=upper=1. Narrow INCR addr=0x3 size=0 len=2 -> 0x3 strb 1000, 0x4 strb 0001, 0x5 strb 0010.
4. Error checks:
   - INCR addr=0xFF8 size=2 len=3 -> page crossing, err=1 on all 4 beats, addrs 0xFF8..0x1004.
   - size=3 -> err=1.
   - burst=11 -> FIXED addresses, err=1.
5. Backpressure and back-to-back:
   - Hold beat_ready_i=0 for 3 cycles mid-burst -> outputs unchanged.
   - Present a second command during the last-beat handshake -> ax_ready_o=1 that cycle; next cycle shows new beat 0 with the new id.
6. Assert arst_i asynchronously at beat 1 of a len=7 INCR -> outputs cleared before the next edge, ax_ready_o=1. A new command after release starts at idx 0.
